// File: rtl/pc_gen_pkg.sv
// ============================================================================
// Module      : pc_gen_pkg
// Description : Shared source/state encodings and defaults for the PC unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_gen_pkg;

    // Encoding value doubles as arbitration priority.
    typedef enum logic [1:0] {
        PC_SRC_SEQ  = 2'd0,
        PC_SRC_BR   = 2'd1,
        PC_SRC_MRET = 2'd2,
        PC_SRC_TRAP = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        PCG_BOOT = 2'd0,
        PCG_RUN  = 2'd1,
        PCG_PEND = 2'd2
    } pcg_state_e;

    localparam logic [31:0] C_DEFAULT_RESET_VEC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/pc_gen_pc_src_arb.sv
// ============================================================================
// Module      : pc_src_arb
// Description : Combinational priority select among trap, mret, branch, seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_src_arb
    import pc_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic [XLEN-1:0] npc_i,
    output logic [1:0]      sel_src_o,
    output logic [XLEN-1:0] sel_pc_o,
    output logic            misalign_o
);

    localparam logic [XLEN-1:0] C_MASK_WORD = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] C_MASK_HALF = {{(XLEN-1){1'b1}}, 1'b0};

    logic w_br_ok;

    // A branch with bit[1] set can never be a legal 4-byte fetch target.
    assign w_br_ok    = br_taken_i & ~br_target_i[1];
    assign misalign_o = br_taken_i & br_target_i[1] & ~trap_i & ~mret_i;

    always_comb begin
        sel_src_o = PC_SRC_SEQ;
        sel_pc_o  = npc_i;
        if (trap_i) begin
            sel_src_o = PC_SRC_TRAP;
            sel_pc_o  = trap_vec_i & C_MASK_WORD;
        end else if (mret_i) begin
            sel_src_o = PC_SRC_MRET;
            sel_pc_o  = mepc_i & C_MASK_WORD;
        end else if (w_br_ok) begin
            sel_src_o = PC_SRC_BR;
            sel_pc_o  = br_target_i & C_MASK_HALF;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
// Module      : pc_gen
// Description : Registered program counter with stall-safe redirect buffering.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(C_DEFAULT_RESET_VEC),
    parameter int              PC_STEP   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] npc_o,
    output logic            fetch_valid_o,
    output logic            redirect_o,
    output logic            misalign_o
);

    pcg_state_e      r_state;
    pcg_state_e      w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_pend_pc;
    logic [XLEN-1:0] w_pend_pc_nxt;
    logic [1:0]      r_pend_src;
    logic [1:0]      w_pend_src_nxt;
    logic            r_redirect;
    logic            w_redirect_nxt;
    logic            r_misalign;
    logic            w_misalign_nxt;
    logic            r_fetch_valid;
    logic            w_fetch_valid_nxt;

    logic [XLEN-1:0] w_npc;
    logic [1:0]      w_arb_src;
    logic [XLEN-1:0] w_arb_pc;
    logic            w_arb_misalign;

    assign w_npc = r_pc + XLEN'(PC_STEP);

    pc_src_arb #(
        .XLEN (XLEN)
    ) u_arb (
        .trap_i      (trap_i),
        .trap_vec_i  (trap_vec_i),
        .mret_i      (mret_i),
        .mepc_i      (mepc_i),
        .br_taken_i  (br_taken_i),
        .br_target_i (br_target_i),
        .npc_i       (w_npc),
        .sel_src_o   (w_arb_src),
        .sel_pc_o    (w_arb_pc),
        .misalign_o  (w_arb_misalign)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pend_pc_nxt  = r_pend_pc;
        w_pend_src_nxt = r_pend_src;
        w_redirect_nxt = 1'b0;
        w_misalign_nxt = 1'b0;
        case (r_state)
            PCG_BOOT: begin
                w_state_nxt = PCG_RUN;
            end
            PCG_RUN: begin
                w_misalign_nxt = w_arb_misalign;
                if (!stall_i) begin
                    w_pc_nxt       = w_arb_pc;
                    w_redirect_nxt = (w_arb_src != PC_SRC_SEQ);
                end else if (w_arb_src != PC_SRC_SEQ) begin
                    w_pend_pc_nxt  = w_arb_pc;
                    w_pend_src_nxt = w_arb_src;
                    w_state_nxt    = PCG_PEND;
                end
            end
            PCG_PEND: begin
                w_misalign_nxt = w_arb_misalign;
                if (stall_i) begin
                    // Newer request wins a tie while still stalled.
                    if ((w_arb_src != PC_SRC_SEQ) && (w_arb_src >= r_pend_src)) begin
                        w_pend_pc_nxt  = w_arb_pc;
                        w_pend_src_nxt = w_arb_src;
                    end
                end else begin
                    // On release the buffered entry wins a tie.
                    w_pc_nxt       = (w_arb_src > r_pend_src) ? w_arb_pc : r_pend_pc;
                    w_redirect_nxt = 1'b1;
                    w_pend_pc_nxt  = '0;
                    w_pend_src_nxt = PC_SRC_SEQ;
                    w_state_nxt    = PCG_RUN;
                end
            end
            default: begin
                w_state_nxt = PCG_RUN;
            end
        endcase
        w_fetch_valid_nxt = (w_state_nxt != PCG_BOOT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= PCG_BOOT;
            r_pc          <= RESET_VEC;
            r_pend_pc     <= '0;
            r_pend_src    <= PC_SRC_SEQ;
            r_redirect    <= 1'b0;
            r_misalign    <= 1'b0;
            r_fetch_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pend_pc     <= w_pend_pc_nxt;
            r_pend_src    <= w_pend_src_nxt;
            r_redirect    <= w_redirect_nxt;
            r_misalign    <= w_misalign_nxt;
            r_fetch_valid <= w_fetch_valid_nxt;
        end
    end

    assign pc_o          = r_pc;
    assign npc_o         = w_npc;
    assign fetch_valid_o = r_fetch_valid;
    assign redirect_o    = r_redirect;
    assign misalign_o    = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
// Module      : tb_pc_gen
// Description : Scoreboard bench for pc_gen using directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic        mret_i;
    logic [31:0] mepc_i;
    logic        trap_i;
    logic [31:0] trap_vec_i;
    logic [31:0] pc_o;
    logic [31:0] npc_o;
    logic        fetch_valid_o;
    logic        redirect_o;
    logic        misalign_o;

    typedef struct {
        logic [31:0] pc;
        logic        red;
        logic        mis;
        logic        fv;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    pc_gen #(
        .XLEN      (32),
        .RESET_VEC (32'h0000_0000),
        .PC_STEP   (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .br_taken_i    (br_taken_i),
        .br_target_i   (br_target_i),
        .mret_i        (mret_i),
        .mepc_i        (mepc_i),
        .trap_i        (trap_i),
        .trap_vec_i    (trap_vec_i),
        .pc_o          (pc_o),
        .npc_o         (npc_o),
        .fetch_valid_o (fetch_valid_o),
        .redirect_o    (redirect_o),
        .misalign_o    (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req)
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        else
            n_pass++;
    endtask

    // Monitor: one expected entry per clock after each stimulus cycle.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc",       pc_o,                e.pc);
            chk("npc",      npc_o,               e.pc + 32'd4);
            chk("redirect", {31'd0, redirect_o}, {31'd0, e.red});
            chk("misalign", {31'd0, misalign_o}, {31'd0, e.mis});
            chk("fvalid",   {31'd0, fetch_valid_o}, {31'd0, e.fv});
        end
    end

    task automatic tick(input logic st, input logic tr, input logic [31:0] tv,
                        input logic mr, input logic [31:0] me,
                        input logic br, input logic [31:0] bt,
                        input logic [31:0] epc, input logic ered, input logic emis);
        exp_t e;
        @(negedge clk);
        stall_i     = st;
        trap_i      = tr;
        trap_vec_i  = tv;
        mret_i      = mr;
        mepc_i      = me;
        br_taken_i  = br;
        br_target_i = bt;
        e.pc  = epc;
        e.red = ered;
        e.mis = emis;
        e.fv  = 1'b1;
        q.push_back(e);
        @(posedge clk);
    endtask

    task automatic chk_idle(input string name, input logic [31:0] epc, input logic efv);
        chk({name, "_pc"},  pc_o, epc);
        chk({name, "_fv"},  {31'd0, fetch_valid_o}, {31'd0, efv});
        chk({name, "_red"}, {31'd0, redirect_o}, 32'd0);
        chk({name, "_mis"}, {31'd0, misalign_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall_i = 0; br_taken_i = 0; br_target_i = 0;
        mret_i = 0; mepc_i = 0; trap_i = 0; trap_vec_i = 0;
        repeat (2) @(posedge clk);
        #1 chk_idle("reset", 32'h0, 1'b0);
        rst_n = 1'b1;
        #1 chk_idle("boot", 32'h0, 1'b0);

        //   st tr tv            mr me            br bt            exp_pc         red mis
        tick(0, 0, 0,            0, 0,            0, 0,            32'h0000_0000, 0, 0);
        tick(0, 0, 0,            0, 0,            0, 0,            32'h0000_0004, 0, 0);
        tick(0, 0, 0,            0, 0,            0, 0,            32'h0000_0008, 0, 0);
        tick(0, 0, 0,            0, 0,            0, 0,            32'h0000_000C, 0, 0);
        tick(0, 1, 32'h203,      0, 0,            1, 32'h100,      32'h0000_0200, 1, 0);
        tick(0, 0, 0,            0, 0,            0, 0,            32'h0000_0204, 0, 0);
        // Stall window with branch then mret buffered.
        tick(1, 0, 0,            0, 0,            1, 32'h40,       32'h0000_0204, 0, 0);
        tick(1, 0, 0,            1, 32'h80,       0, 0,            32'h0000_0204, 0, 0);
        tick(1, 0, 0,            0, 0,            0, 0,            32'h0000_0204, 0, 0);
        tick(0, 0, 0,            0, 0,            0, 0,            32'h0000_0080, 1, 0);
        tick(0, 0, 0,            0, 0,            0, 0,            32'h0000_0084, 0, 0);
        tick(0, 0, 0,            0, 0,            0, 0,            32'h0000_0088, 0, 0);
        // Pending trap beats a live branch on release.
        tick(1, 1, 32'h300,      0, 0,            0, 0,            32'h0000_0088, 0, 0);
        tick(0, 0, 0,            0, 0,            1, 32'h500,      32'h0000_0300, 1, 0);
        tick(0, 0, 0,            0, 0,            0, 0,            32'h0000_0304, 0, 0);
        // Misaligned branch falls through to sequential.
        tick(0, 0, 0,            0, 0,            1, 32'h10,       32'h0000_0010, 1, 0);
        tick(0, 0, 0,            0, 0,            1, 32'h102,      32'h0000_0014, 0, 1);
        tick(0, 0, 0,            0, 0,            0, 0,            32'h0000_0018, 0, 0);
        // Wrap-around.
        tick(0, 0, 0,            0, 0,            1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0);
        tick(0, 0, 0,            0, 0,            0, 0,            32'h0000_0000, 0, 0);
        // Target masking.
        tick(0, 0, 0,            1, 32'h87,       0, 0,            32'h0000_0084, 1, 0);
        tick(0, 0, 0,            0, 0,            1, 32'h121,      32'h0000_0120, 1, 0);
        // Ties: newer wins while stalled, pending wins on release.
        tick(1, 0, 0,            0, 0,            1, 32'h40,       32'h0000_0120, 0, 0);
        tick(1, 0, 0,            0, 0,            1, 32'h60,       32'h0000_0120, 0, 0);
        tick(0, 0, 0,            0, 0,            0, 0,            32'h0000_0060, 1, 0);
        tick(1, 0, 0,            0, 0,            1, 32'h70,       32'h0000_0060, 0, 0);
        tick(0, 0, 0,            0, 0,            1, 32'h90,       32'h0000_0070, 1, 0);
        // Reset while a trap is pending.
        tick(1, 1, 32'h400,      0, 0,            0, 0,            32'h0000_0070, 0, 0);
        #3 rst_n = 1'b0;
        stall_i = 0; trap_i = 0; trap_vec_i = 0;
        #1 chk_idle("async_rst", 32'h0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk_idle("boot2", 32'h0, 1'b0);
        tick(0, 0, 0,            0, 0,            0, 0,            32'h0000_0000, 0, 0);
        tick(0, 0, 0,            0, 0,            0, 0,            32'h0000_0004, 0, 0);
        tick(0, 0, 0,            0, 0,            0, 0,            32'h0000_0008, 0, 0);

        @(posedge clk);
        #3 chk("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
